// File: rtl/tdc_edge_accum.sv
// TDC edge accumulator: thermometer popcount and windowed sum/min/max.
// Optional majority bubble filter before capture: TDC_BUBBLE_FILTER_EN.
module tdc_edge_accum #(
  parameter int WIDTH  = 64,
  parameter int LOG2_N = 4,
  parameter int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        tdc_data,
  input  logic                    data_valid,
  output logic [CNT_W+LOG2_N-1:0] out_sum,
  output logic [CNT_W-1:0]        out_min,
  output logic [CNT_W-1:0]        out_max,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             drop_count
);

  localparam int SUM_W = CNT_W + LOG2_N;

  logic [WIDTH-1:0]  cap_d;
  logic [WIDTH-1:0]  s1_data;
  logic              s1_vld;
  logic [CNT_W-1:0]  pc;
  logic [CNT_W-1:0]  s2_pc;
  logic              s2_vld;
  logic [SUM_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  acc_min;
  logic [CNT_W-1:0]  acc_max;
  logic [LOG2_N-1:0] smp_cnt;
  logic [SUM_W-1:0]  nxt_sum;
  logic [CNT_W-1:0]  nxt_min;
  logic [CNT_W-1:0]  nxt_max;
  logic              win_close;

`ifdef TDC_BUBBLE_FILTER_EN
  // Padded so tap -1 reads as filled and tap WIDTH as empty.
  logic [WIDTH+1:0] ext;
  assign ext = {1'b0, tdc_data, 1'b1};
  always_comb begin
    cap_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cap_d[i] = (ext[i] & ext[i+1])
               | (ext[i+1] & ext[i+2])
               | (ext[i] & ext[i+2]);
    end
  end
`else
  assign cap_d = tdc_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= data_valid;
      if (data_valid) s1_data <= cap_d;
    end
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + CNT_W'(s1_data[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_pc  <= '0;
      s2_vld <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) s2_pc <= pc;
    end
  end

  always_comb begin
    nxt_sum   = acc_sum + SUM_W'(s2_pc);
    nxt_min   = (s2_pc < acc_min) ? s2_pc : acc_min;
    nxt_max   = (s2_pc > acc_max) ? s2_pc : acc_max;
    win_close = s2_vld && (&smp_cnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_sum <= '0;
      acc_min <= CNT_W'(WIDTH);
      acc_max <= '0;
      smp_cnt <= '0;
    end else if (s2_vld) begin
      smp_cnt <= smp_cnt + 1'b1;
      if (win_close) begin
        acc_sum <= '0;
        acc_min <= CNT_W'(WIDTH);
        acc_max <= '0;
      end else begin
        acc_sum <= nxt_sum;
        acc_min <= nxt_min;
        acc_max <= nxt_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sum    <= '0;
      out_min    <= '0;
      out_max    <= '0;
      out_valid  <= 1'b0;
      drop_count <= '0;
    end else if (win_close) begin
      if (!out_valid || out_ready) begin
        out_sum   <= nxt_sum;
        out_min   <= nxt_min;
        out_max   <= nxt_max;
        out_valid <= 1'b1;
      end else if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_edge_accum.sv
// Directed bench for tdc_edge_accum: window table plus handshake/reset cases.
module tb_tdc_edge_accum;

  logic        clk;
  logic        rst_n;
  logic [63:0] tdc_data;
  logic        data_valid;
  logic [10:0] out_sum;
  logic [6:0]  out_min;
  logic [6:0]  out_max;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] drop_count;

  int n_chk;
  int n_err;

  tdc_edge_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tdc_data   (tdc_data),
    .data_valid (data_valid),
    .out_sum    (out_sum),
    .out_min    (out_min),
    .out_max    (out_max),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] dr;
    int          sum;
    int          mn;
    int          mx;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // 16 samples: d0, d1, then 14 of dr; returns one cycle after the last.
  task automatic drive_win(input logic [63:0] d0,
                           input logic [63:0] d1,
                           input logic [63:0] dr);
    for (int k = 0; k < 16; k++) begin
      tdc_data   = (k == 0) ? d0 : (k == 1) ? d1 : dr;
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    tdc_data   = '0;
  endtask

  task automatic chk_out(input string nm, input int s,
                         input int mn, input int mx);
    chk({nm, " sum"}, int'(out_sum), s);
    chk({nm, " min"}, int'(out_min), mn);
    chk({nm, " max"}, int'(out_max), mx);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    tdc_data   = '0;
    data_valid = 1'b0;
    out_ready  = 1'b1;

    vecs[0] = '{"steady", 64'h0000_0000_000F_FFFF, 64'h0000_0000_000F_FFFF,
                64'h0000_0000_000F_FFFF, 320, 20, 20};
    vecs[1] = '{"extremes", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0000_0000_FFFF_FFFF, 512, 0, 64};
`ifdef TDC_BUBBLE_FILTER_EN
    vecs[2] = '{"bubble", 64'h0000_0000_FFFF_FBFF, 64'h0000_0000_FFFF_FBFF,
                64'h0000_0000_FFFF_FBFF, 512, 32, 32};
`else
    vecs[2] = '{"bubble", 64'h0000_0000_FFFF_FBFF, 64'h0000_0000_FFFF_FBFF,
                64'h0000_0000_FFFF_FBFF, 496, 31, 31};
`endif
    vecs[3] = '{"mixed", 64'h1, 64'h7, 64'hFF, 116, 1, 8};
    vecs[4] = '{"zeros", 64'h0, 64'h0, 64'h0, 0, 0, 0};
    vecs[5] = '{"ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 1024, 64, 64};

    tick();
    tick();
    chk("rst valid", int'(out_valid), 0);
    chk_out("rst", 0, 0, 0);
    chk("rst drop", int'(drop_count), 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive_win(vecs[i].d0, vecs[i].d1, vecs[i].dr);
      chk({vecs[i].name, " t+1 valid"}, int'(out_valid), 0);
      tick();
      chk({vecs[i].name, " t+2 valid"}, int'(out_valid), 0);
      tick();
      chk({vecs[i].name, " t+3 valid"}, int'(out_valid), 1);
      chk_out(vecs[i].name, vecs[i].sum, vecs[i].mn, vecs[i].mx);
      tick();
      chk({vecs[i].name, " accept"}, int'(out_valid), 0);
    end

    // Close and accept on the same cycle.
    out_ready = 1'b0;
    drive_win(64'h3, 64'h3, 64'h3);
    tick();
    tick();
    chk("ca first valid", int'(out_valid), 1);
    chk_out("ca first", 32, 2, 2);
    drive_win(64'hF, 64'hF, 64'hF);
    tick();
    chk("ca held", int'(out_sum), 32);
    out_ready = 1'b1;
    tick();
    chk("ca valid", int'(out_valid), 1);
    chk_out("ca second", 64, 4, 4);
    chk("ca drop", int'(drop_count), 0);
    tick();
    chk("ca clear", int'(out_valid), 0);

    // Backpressure across two closes.
    out_ready = 1'b0;
    drive_win(64'hF_FFFF, 64'hF_FFFF, 64'hF_FFFF);
    tick();
    tick();
    chk("bp first valid", int'(out_valid), 1);
    chk_out("bp first", 320, 20, 20);
    drive_win(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    tick();
    chk("bp valid", int'(out_valid), 1);
    chk_out("bp held", 320, 20, 20);
    chk("bp drop", int'(drop_count), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp clear", int'(out_valid), 0);
    chk("bp stable", int'(out_sum), 320);
    tick();
    chk("bp stays clear", int'(out_valid), 0);

    // Reset in the middle of a window.
    for (int k = 0; k < 7; k++) begin
      tdc_data   = 64'hFFFF;
      data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid rst valid", int'(out_valid), 0);
    chk_out("mid rst", 0, 0, 0);
    chk("mid rst drop", int'(drop_count), 0);
    drive_win(64'h3FF, 64'h3FF, 64'h3FF);
    chk("post rst t+1", int'(out_valid), 0);
    tick();
    chk("post rst t+2", int'(out_valid), 0);
    tick();
    chk("post rst valid", int'(out_valid), 1);
    chk_out("post rst", 160, 10, 10);
    chk("post rst drop", int'(drop_count), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
